// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline register with a second skid entry: the main entry drives decode,
// and the skid entry absorbs one fetch that arrives while decode is stalled.
module if_id_skid_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      instr_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      instr_o,
  output logic             valid_o,
  output logic [4:0]       RSaddr_o,
  output logic [4:0]       RTaddr_o,
  output logic [4:0]       RDaddr_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [31:0]      pc_r;
  logic [31:0]      instr_r;
  logic             valid_r;
  logic             ready_r;
  logic [31:0]      skid_pc_r;
  logic [31:0]      skid_instr_r;
  logic [CNT_W-1:0] bubble_cnt_r;

  logic accept_s;
  logic advance_s;
  logic load_in_s;
  logic load_skid_s;
  logic skid_fill_s;
  logic drain_s;

  assign accept_s  = valid_i & ready_r;
  assign advance_s = valid_r & ~stall_i;

  // State register
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; flush beats every other condition
  always_comb begin
    state_s = state_r;
    if (flush_i) begin
      state_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY:   state_s = accept_s ? ONE : EMPTY;
        ONE: begin
          if (accept_s && !advance_s) begin
            state_s = TWO;
          end else if (!accept_s && advance_s) begin
            state_s = EMPTY;
          end else begin
            state_s = ONE;
          end
        end
        TWO:     state_s = advance_s ? ONE : TWO;
        default: state_s = EMPTY;
      endcase
    end
  end

  // Datapath steering for the main and skid entries
  always_comb begin
    load_in_s   = 1'b0;
    load_skid_s = 1'b0;
    skid_fill_s = 1'b0;
    drain_s     = 1'b0;
    if (flush_i) begin
      drain_s = 1'b0;
    end else begin
      case (state_r)
        EMPTY: load_in_s = accept_s;
        ONE: begin
          if (accept_s && advance_s) begin
            load_in_s = 1'b1;
          end else if (accept_s) begin
            skid_fill_s = 1'b1;
          end else if (advance_s) begin
            drain_s = 1'b1;
          end else begin
            load_in_s = 1'b0;
          end
        end
        TWO:     load_skid_s = advance_s;
        default: drain_s = 1'b1;
      endcase
    end
  end

  // Main entry, skid entry and registered ready; pc_o is kept across bubbles
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      pc_r         <= 32'h0000_0000;
      instr_r      <= NOP_INSTR;
      valid_r      <= 1'b0;
      ready_r      <= 1'b1;
      skid_pc_r    <= 32'h0000_0000;
      skid_instr_r <= 32'h0000_0000;
    end else begin
      ready_r <= (state_s != TWO);
      if (flush_i || drain_s) begin
        instr_r <= NOP_INSTR;
        valid_r <= 1'b0;
      end else if (load_in_s) begin
        pc_r    <= pc_i;
        instr_r <= instr_i;
        valid_r <= 1'b1;
      end else if (load_skid_s) begin
        pc_r    <= skid_pc_r;
        instr_r <= skid_instr_r;
        valid_r <= 1'b1;
      end else begin
        valid_r <= valid_r;
      end
      if (flush_i || load_skid_s) begin
        skid_pc_r    <= 32'h0000_0000;
        skid_instr_r <= 32'h0000_0000;
      end else if (skid_fill_s) begin
        skid_pc_r    <= pc_i;
        skid_instr_r <= instr_i;
      end else begin
        skid_pc_r <= skid_pc_r;
      end
    end
  end

  // Saturating count of cycles that leave the stage without an instruction
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      bubble_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_s == EMPTY) && (bubble_cnt_r != {CNT_W{1'b1}})) begin
      bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign ready_o      = ready_r;
  assign valid_o      = valid_r;
  assign pc_o         = pc_r;
  assign instr_o      = instr_r;
  assign bubble_cnt_o = bubble_cnt_r;
  assign RSaddr_o     = instr_r[19:15];
  assign RTaddr_o     = instr_r[24:20];
  assign RDaddr_o     = instr_r[11:7];

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Scoreboard bench for if_id_skid_stage: a small occupancy model predicts ready/valid,
// accepted fetches are queued and compared in order as decode retires them.
module tb_if_id_skid_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        valid_i;
  logic        ready_o;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        valid_o;
  logic [4:0]  RSaddr_o;
  logic [4:0]  RTaddr_o;
  logic [4:0]  RDaddr_o;
  logic [15:0] bubble_cnt_o;

  item_t       sb_q[$];
  int          model_cnt;
  logic [15:0] bub_model;
  int          checks;
  int          errors;
  int          retired;
  logic        ret_s;
  logic        acc_s;
  item_t       obs_item;
  item_t       exp_item;

  if_id_skid_stage #(.NOP_INSTR(32'h0000_0013), .CNT_W(16)) dut (
    .CLK(CLK), .nRESET(nRESET), .pc_i(pc_i), .instr_i(instr_i), .valid_i(valid_i),
    .ready_o(ready_o), .stall_i(stall_i), .flush_i(flush_i), .pc_o(pc_o),
    .instr_o(instr_o), .valid_o(valid_o), .RSaddr_o(RSaddr_o), .RTaddr_o(RTaddr_o),
    .RDaddr_o(RDaddr_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 CLK = ~CLK;

  // One clock: drive inputs, advance the model, capture what decode saw before the edge
  task automatic tick(input logic v, input logic [31:0] p, input logic [31:0] ins,
                      input logic s, input logic f);
    logic adv;
    valid_i  = v;
    pc_i     = p;
    instr_i  = ins;
    stall_i  = s;
    flush_i  = f;
    acc_s    = v && (model_cnt < 2);
    adv      = (model_cnt > 0) && !s;
    ret_s    = 1'b0;
    obs_item = {pc_o, instr_o};
    if (f) begin
      sb_q.delete();
      model_cnt = 0;
    end else begin
      if (adv) begin
        ret_s    = 1'b1;
        exp_item = sb_q.pop_front();
        retired++;
        model_cnt--;
      end
      if (acc_s) begin
        sb_q.push_back({p, ins});
        model_cnt++;
      end
    end
    if ((model_cnt == 0) && (bub_model != 16'hFFFF)) bub_model++;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] mk_instr(input int k);
    logic [4:0] a;
    a = 5'(k);
    return {7'd0, a + 5'd3, a + 5'd1, 3'b000, a + 5'd2, 7'h33};
  endfunction

  task automatic test_reset();
    nRESET = 1'b0;
    valid_i = 1'b0; pc_i = 32'h0; instr_i = 32'h0; stall_i = 1'b0; flush_i = 1'b0;
    sb_q.delete(); model_cnt = 0; bub_model = 16'h0; retired = 0;
    #12;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'h0000_0013 ||
        bubble_cnt_o !== 16'h0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b pc=%h instr=%h bub=%h, want 0 1 0 00000013 0",
               valid_o, ready_o, pc_o, instr_o, bubble_cnt_o);
    end
    nRESET = 1'b1;
  endtask

  task automatic test_single();
    tick(1'b1, 32'h100, 32'h00A0_0093, 1'b0, 1'b0);
    checks++;
    if (valid_o !== 1'b1 || pc_o !== 32'h100 || RDaddr_o !== 5'd1 || RSaddr_o !== 5'd0 ||
        RTaddr_o !== 5'd10) begin
      errors++;
      $display("FAIL single: valid=%b pc=%h rd=%0d rs=%0d rt=%0d, want 1 100 1 0 10",
               valid_o, pc_o, RDaddr_o, RSaddr_o, RTaddr_o);
    end
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (!ret_s || obs_item !== exp_item) begin
      errors++;
      $display("FAIL single_retire: ret=%b got %h want %h", ret_s, obs_item, exp_item);
    end
    checks++;
    if (valid_o !== 1'b0 || instr_o !== 32'h0000_0013 || RDaddr_o !== 5'd0 ||
        RSaddr_o !== 5'd0 || RTaddr_o !== 5'd0 || bubble_cnt_o !== bub_model) begin
      errors++;
      $display("FAIL bubble_out: valid=%b instr=%h rd=%0d rs=%0d rt=%0d bub=%0d want 0 00000013 0 0 0 %0d",
               valid_o, instr_o, RDaddr_o, RSaddr_o, RTaddr_o, bubble_cnt_o, bub_model);
    end
  endtask

  task automatic test_stall_stream();
    int   idx;
    int   base;
    logic saw_full;
    idx = 0; base = retired; saw_full = 1'b0;
    for (int c = 0; c < 20 && !(idx == 3 && model_cnt == 0); c++) begin
      tick(idx < 3, 32'h100 + 32'(idx * 4), mk_instr(idx), (c == 1) || (c == 2), 1'b0);
      if (acc_s && idx < 3) idx++;
      if (ready_o === 1'b0) saw_full = 1'b1;
      checks++;
      if (ready_o !== (model_cnt < 2) || valid_o !== (model_cnt > 0)) begin
        errors++;
        $display("FAIL stall_flags: ready=%b valid=%b want %b %b", ready_o, valid_o,
                 model_cnt < 2, model_cnt > 0);
      end
      if (ret_s) begin
        checks++;
        if (obs_item !== exp_item) begin
          errors++;
          $display("FAIL stall_order: got %h want %h", obs_item, exp_item);
        end
      end
    end
    checks++;
    if (retired - base != 3 || !saw_full || sb_q.size() != 0) begin
      errors++;
      $display("FAIL stall_count: retired=%0d saw_full=%b left=%0d want 3 1 0",
               retired - base, saw_full, sb_q.size());
    end
  endtask

  task automatic test_flush_two();
    tick(1'b1, 32'h200, mk_instr(7), 1'b0, 1'b0);
    tick(1'b1, 32'h204, mk_instr(8), 1'b1, 1'b0);
    checks++;
    if (ready_o !== 1'b0) begin
      errors++;
      $display("FAIL two_ready: ready=%b want 0", ready_o);
    end
    tick(1'b1, 32'h208, mk_instr(9), 1'b0, 1'b1);
    checks++;
    if (valid_o !== 1'b0 || instr_o !== 32'h0000_0013 || ready_o !== 1'b1 || pc_o !== 32'h200) begin
      errors++;
      $display("FAIL flush_two: valid=%b instr=%h ready=%b pc=%h want 0 00000013 1 200",
               valid_o, instr_o, ready_o, pc_o);
    end
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (valid_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_leak: valid=%b pc=%h instr=%h want valid 0", valid_o, pc_o, instr_o);
      end
    end
  endtask

  task automatic test_flush_stall();
    tick(1'b1, 32'h300, mk_instr(11), 1'b0, 1'b0);
    tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || instr_o !== 32'h0000_0013 || pc_o !== 32'h300 ||
        bubble_cnt_o !== bub_model) begin
      errors++;
      $display("FAIL flush_stall: valid=%b ready=%b instr=%h pc=%h bub=%0d want 0 1 00000013 300 %0d",
               valid_o, ready_o, instr_o, pc_o, bubble_cnt_o, bub_model);
    end
  endtask

  task automatic test_back_to_back();
    int idx;
    int base;
    idx = 0; base = retired;
    for (int c = 0; c < 300 && !(idx == 10 && model_cnt == 0); c++) begin
      tick((idx < 10) && ($urandom_range(0, 3) != 0), 32'h1000 + 32'(idx * 4), mk_instr(idx + 20),
           $urandom_range(0, 2) == 0, 1'b0);
      if (acc_s && idx < 10) idx++;
      checks++;
      if (ready_o !== (model_cnt < 2) || valid_o !== (model_cnt > 0)) begin
        errors++;
        $display("FAIL b2b_flags: ready=%b valid=%b want %b %b", ready_o, valid_o,
                 model_cnt < 2, model_cnt > 0);
      end
      if (ret_s) begin
        checks++;
        if (obs_item !== exp_item) begin
          errors++;
          $display("FAIL b2b_order: got %h want %h", obs_item, exp_item);
        end
      end
      if (valid_o === 1'b1 && model_cnt > 0) begin
        checks++;
        if (RSaddr_o !== sb_q[0].instr[19:15] || RTaddr_o !== sb_q[0].instr[24:20] ||
            RDaddr_o !== sb_q[0].instr[11:7]) begin
          errors++;
          $display("FAIL b2b_decode: rs=%0d rt=%0d rd=%0d for instr %h", RSaddr_o, RTaddr_o,
                   RDaddr_o, sb_q[0].instr);
        end
      end
    end
    checks++;
    if (retired - base != 10) begin
      errors++;
      $display("FAIL b2b_count: retired=%0d want 10", retired - base);
    end
  endtask

  task automatic test_bubble_sat();
    for (int c = 0; c < 65541; c++) tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (bubble_cnt_o !== 16'hFFFF || bubble_cnt_o !== bub_model) begin
      errors++;
      $display("FAIL bubble_sat: bub=%h want ffff", bubble_cnt_o);
    end
    for (int c = 0; c < 3; c++) tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (bubble_cnt_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL bubble_hold: bub=%h want ffff", bubble_cnt_o);
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 32'h400, mk_instr(3), 1'b0, 1'b0);
    tick(1'b1, 32'h404, mk_instr(4), 1'b1, 1'b0);
    #2;
    nRESET = 1'b0;
    #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || instr_o !== 32'h0000_0013 || pc_o !== 32'h0 ||
        bubble_cnt_o !== 16'h0) begin
      errors++;
      $display("FAIL async_reset: valid=%b ready=%b instr=%h pc=%h bub=%h want 0 1 00000013 0 0",
               valid_o, ready_o, instr_o, pc_o, bubble_cnt_o);
    end
    sb_q.delete(); model_cnt = 0; bub_model = 16'h0;
    nRESET = 1'b1;
    tick(1'b1, 32'h500, mk_instr(5), 1'b0, 1'b0);
    checks++;
    if (valid_o !== 1'b1 || pc_o !== 32'h500 || instr_o !== mk_instr(5)) begin
      errors++;
      $display("FAIL post_reset: valid=%b pc=%h instr=%h want 1 500 %h", valid_o, pc_o, instr_o,
               mk_instr(5));
    end
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (!ret_s || obs_item !== exp_item || bubble_cnt_o !== bub_model) begin
      errors++;
      $display("FAIL post_reset_retire: got %h want %h bub=%0d want %0d", obs_item, exp_item,
               bubble_cnt_o, bub_model);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_stall_stream();
    test_flush_two();
    test_flush_stall();
    test_back_to_back();
    test_bubble_sat();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
